// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg
// Shared constants for the stream demultiplexer: default geometry and the
// encoding of the mode input.
//   DEFAULT_WIDTH : payload bits per beat
//   DEFAULT_N     : output channel count (power of two, >= 2)
//   MODE_ADDR     : mode value selecting the channel from in_sel
//   MODE_RR       : mode value selecting the channel from rr_ptr
package stream_demux_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_N     = 8;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_RR   = 1'b1;

endpackage

// File: rtl/stream_demux_slot.sv
// demux_slot
// One-entry register slice holding a single beat for one output channel.
// A write and a read on the same edge leave the slot full with the new beat,
// so a continuously streaming channel runs at one beat per cycle.
// The data register resets to zero and otherwise keeps its last value once
// drained; only the valid flag tracks occupancy.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset (clears valid and data)
//   wr_en    : load din this edge (caller guarantees slot is free or draining)
//   din      : incoming payload
//   rd_ready : downstream accepts the held beat this edge
//   valid    : slot holds a beat
//   dout     : held payload
module demux_slot
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_ready,
    output logic             valid,
    output logic [WIDTH-1:0] dout
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            dout  <= '0;
        end else begin
            if (wr_en) begin
                // Refill takes priority over drain: covers the same-edge
                // drain+refill case without a bubble.
                valid <= 1'b1;
                dout  <= din;
            end else if (valid && rd_ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/stream_demux.sv
// stream_demux
// Routes a single valid/ready input stream to one of N output channels.
// Each channel owns a one-entry slot, so a stalled channel only blocks beats
// that target it. The target is in_sel in addressed mode, or rr_ptr in
// round-robin mode; rr_ptr advances only on accepted round-robin beats.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : upstream beat present
//   in_data   : upstream payload (WIDTH bits)
//   in_sel    : target channel in addressed mode (SELW bits)
//   mode      : MODE_ADDR (use in_sel) or MODE_RR (use rr_ptr)
//   in_ready  : target slot can take a beat this cycle
//   out_valid : per-channel beat present (N bits)
//   out_data  : channel i payload on [i*WIDTH +: WIDTH]
//   out_ready : per-channel downstream acceptance (N bits)
//   rr_ptr    : next round-robin target
//   xfer_cnt  : accepted input beats, wraps at 16 bits
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int N     = DEFAULT_N,
    localparam int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SELW-1:0]    in_sel,
    input  logic               mode,
    output logic               in_ready,
    output logic [N-1:0]       out_valid,
    output logic [N*WIDTH-1:0] out_data,
    input  logic [N-1:0]       out_ready,
    output logic [SELW-1:0]    rr_ptr,
    output logic [15:0]        xfer_cnt
);

    logic [SELW-1:0] target;
    logic [N-1:0]    slot_valid;
    logic [N-1:0]    slot_wr;
    logic            accept;

    // Target is purely combinational, so a mode change is seen by the very
    // next cycle's acceptance decision; beats already in slots are untouched.
    always_comb begin
        target = in_sel;
        if (mode == MODE_RR) begin
            target = rr_ptr;
        end
    end

    // A full slot whose consumer is taking the beat this edge counts as free.
    assign in_ready = ~slot_valid[target] | out_ready[target];
    assign accept   = in_valid & in_ready;

    for (genvar i = 0; i < N; i++) begin : g_slot
        assign slot_wr[i] = accept && (target == SELW'(i));

        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (slot_wr[i]),
            .din      (in_data),
            .rd_ready (out_ready[i]),
            .valid    (slot_valid[i]),
            .dout     (out_data[i*WIDTH +: WIDTH])
        );
    end

    assign out_valid = slot_valid;

    // N is a power of two, so natural SELW-bit overflow is the modulo-N wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept && (mode == MODE_RR)) begin
            rr_ptr <= rr_ptr + SELW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (accept) begin
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux
// Scoreboard bench for stream_demux. The driver issues one cycle of stimulus
// per call and pushes every beat it expects to be accepted into a per-channel
// expected queue; an independent monitor compares the DUT channel outputs
// against the queue heads and pops on output handshakes.
module tb_stream_demux;

    localparam int WIDTH = 8;
    localparam int N     = 8;
    localparam int SELW  = $clog2(N);

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic [WIDTH-1:0]   in_data;
    logic [SELW-1:0]    in_sel;
    logic               mode;
    logic               in_ready;
    logic [N-1:0]       out_valid;
    logic [N*WIDTH-1:0] out_data;
    logic [N-1:0]       out_ready;
    logic [SELW-1:0]    rr_ptr;
    logic [15:0]        xfer_cnt;

    stream_demux #(.WIDTH(WIDTH), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .mode      (mode),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .rr_ptr    (rr_ptr),
        .xfer_cnt  (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: per-channel FIFO of beats owed, round-robin position,
    // and accepted-beat count.
    logic [WIDTH-1:0] exp_q [N][$];
    int               rr_model;
    int               cnt_model;
    bit               mon_en;

    int n_checks;
    int n_fail;

    task automatic chk(input string name, input int ch, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s ch=%0d got=%0h expected=%0h t=%0t", name, ch, act, exp, $time);
        end
    endtask

    // Monitor: 2 time units after each edge, DUT state reflects that edge.
    always @(posedge clk) begin
        #2;
        if (mon_en) begin
            for (int i = 0; i < N; i++) begin
                chk("out_valid", i, 32'(out_valid[i]), 32'(exp_q[i].size() > 0));
                if (exp_q[i].size() > 0) begin
                    chk("out_data", i, 32'(out_data[i*WIDTH +: WIDTH]), 32'(exp_q[i][0]));
                    // Handshake will complete on the coming edge.
                    if (out_ready[i]) void'(exp_q[i].pop_front());
                end
            end
            chk("rr_ptr", -1, 32'(rr_ptr), 32'(rr_model));
            chk("xfer_cnt", -1, 32'(xfer_cnt), 32'(cnt_model[15:0]));
        end
    end

    // One clock of stimulus: drive at +1, predict acceptance at +3 (after the
    // monitor retired beats leaving on the coming edge, so an empty queue here
    // means "slot empty or draining now").
    task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input int sel,
                         input logic m, input logic [N-1:0] ordy);
        int  t;
        bit  exp_rdy;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        in_sel    = SELW'(sel);
        mode      = m;
        out_ready = ordy;
        #2;
        t       = m ? rr_model : sel;
        exp_rdy = (exp_q[t].size() == 0);
        chk("in_ready", t, 32'(in_ready), 32'(exp_rdy));
        if (v && exp_rdy) begin
            exp_q[t].push_back(d);
            if (m) rr_model = (rr_model + 1) % N;
            cnt_model = (cnt_model + 1) % 65536;
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) exp_q[i].delete();
        rr_model  = 0;
        cnt_model = 0;
    endtask

    task automatic do_reset();
        mon_en    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = '0;
        in_sel    = '0;
        mode      = 1'b0;
        out_ready = '0;
        #1;
        chk("rst_in_ready", 0, 32'(in_ready), 32'd1);
        chk("rst_out_valid", -1, 32'(out_valid), 32'd0);
        chk("rst_out_data", -1, out_data[31:0], 32'd0);
        chk("rst_rr_ptr", -1, 32'(rr_ptr), 32'd0);
        chk("rst_xfer_cnt", -1, 32'(xfer_cnt), 32'd0);
        in_valid = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rr_model  = 0;
        cnt_model = 0;
        do_reset();

        // Single addressed beat to channel 3.
        cycle(1'b1, 8'hA5, 3, 1'b0, '1);
        cycle(1'b0, 8'h00, 0, 1'b0, '1);
        chk("d1_out_valid", 3, 32'(out_valid), 32'h08);
        chk("d1_out_data", 3, 32'(out_data[31:24]), 32'hA5);
        chk("d1_xfer_cnt", -1, 32'(xfer_cnt), 32'd1);
        cycle(1'b0, 8'h00, 0, 1'b0, '1);
        chk("d1_drained", 3, 32'(out_valid), 32'h00);

        // Back-pressure and same-edge drain+refill on channel 2.
        cycle(1'b1, 8'h11, 2, 1'b0, '0);
        cycle(1'b1, 8'h22, 2, 1'b0, '0);
        chk("d2_blocked", 2, 32'(in_ready), 32'd0);
        cycle(1'b1, 8'h22, 2, 1'b0, 8'b0000_0100);
        chk("d2_refill_rdy", 2, 32'(in_ready), 32'd1);
        cycle(1'b0, 8'h00, 0, 1'b0, '0);
        chk("d2_full", 2, 32'(out_valid[2]), 32'd1);
        chk("d2_new_data", 2, 32'(out_data[23:16]), 32'h22);
        cycle(1'b0, 8'h00, 0, 1'b0, '1);

        // Round-robin: ten beats land on channels 0..7,0,1.
        for (int j = 0; j <= 10; j++) begin
            cycle(j < 10, WIDTH'(j), 0, 1'b1, '1);
            if (j > 0) begin
                chk("rr_valid", (j - 1) % N, 32'(out_valid), 32'(1 << ((j - 1) % N)));
                chk("rr_data", (j - 1) % N, 32'(out_data[((j - 1) % N)*WIDTH +: WIDTH]), 32'(j - 1));
            end
        end
        chk("rr_end_ptr", -1, 32'(rr_ptr), 32'd2);

        // Stalled channel 5 does not block channel 6.
        cycle(1'b1, 8'h55, 5, 1'b0, ~8'b0010_0000);
        cycle(1'b1, 8'h66, 6, 1'b0, ~8'b0010_0000);
        cycle(1'b0, 8'h00, 0, 1'b0, ~8'b0010_0000);
        chk("iso_ch6_valid", 6, 32'(out_valid[6]), 32'd1);
        chk("iso_ch6_data", 6, 32'(out_data[55:48]), 32'h66);
        chk("iso_ch5_data", 5, 32'(out_data[47:40]), 32'h55);
        cycle(1'b0, 8'h00, 0, 1'b0, ~8'b0010_0000);
        chk("iso_ch5_hold", 5, 32'(out_valid), 32'h20);
        chk("iso_ch5_stable", 5, 32'(out_data[47:40]), 32'h55);
        cycle(1'b0, 8'h00, 0, 1'b0, '1);

        // Asynchronous reset between edges with channels 1 and 4 full.
        cycle(1'b1, 8'h41, 1, 1'b0, '0);
        cycle(1'b1, 8'h44, 4, 1'b0, '0);
        cycle(1'b0, 8'h00, 0, 1'b0, '0);
        chk("ar_prefill", -1, 32'(out_valid), 32'h12);
        #1;
        mon_en = 0;
        rst_n  = 1'b0;
        #1;
        chk("ar_out_valid", -1, 32'(out_valid), 32'd0);
        chk("ar_xfer_cnt", -1, 32'(xfer_cnt), 32'd0);
        chk("ar_rr_ptr", -1, 32'(rr_ptr), 32'd0);
        chk("ar_out_data", -1, out_data[63:32], 32'd0);
        do_reset();

        // Randomized traffic with occasional mode changes.
        for (int k = 0; k < 3000; k++) begin
            cycle(1'($urandom_range(0, 3) != 0), WIDTH'($urandom),
                  int'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)),
                  N'($urandom));
        end
        repeat (2) cycle(1'b0, 8'h00, 0, 1'b0, '1);

        // Counter wrap: 65535 beats from reset, then one more.
        do_reset();
        for (int k = 0; k < 65535; k++) begin
            cycle(1'b1, WIDTH'($urandom), int'($urandom_range(0, N - 1)), 1'b0, '1);
        end
        cycle(1'b0, 8'h00, 0, 1'b0, '1);
        chk("wrap_ffff", -1, 32'(xfer_cnt), 32'h0000_FFFF);
        cycle(1'b1, 8'h5A, 0, 1'b0, '1);
        cycle(1'b0, 8'h00, 0, 1'b0, '1);
        chk("wrap_zero", -1, 32'(xfer_cnt), 32'd0);
        cycle(1'b0, 8'h00, 0, 1'b0, '1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter: WIDTH, default 8, data bits per beat.
REQ-002 Parameter: N, default 8, output channel count; power of two, N >= 2.
REQ-003 Parameter: SELW, default $clog2(N), select width; derived, not overridden.
REQ-004 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-005 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port: in_valid  input  1  upstream beat present.
REQ-007 Port: in_data  input  WIDTH  upstream beat payload.
REQ-008 Port: in_sel  input  SELW  target channel in addressed mode.
REQ-009 Port: mode  input  1  0 = addressed (in_sel), 1 = round-robin (rr_ptr).
REQ-010 Port: in_ready  output  1  beat accepted this cycle when in_valid is also high.
REQ-011 Port: out_valid  output  N  per-channel beat present.
REQ-012 Port: out_data  output  N*WIDTH  channel i payload on bits [i*WIDTH +: WIDTH].
REQ-013 Port: out_ready  input  N  per-channel downstream acceptance.
REQ-014 Port: rr_ptr  output  SELW  next round-robin target.
REQ-015 Port: xfer_cnt  output  16  count of accepted input beats.

Function
REQ-016 Target channel t SHALL be in_sel when mode=0, rr_ptr when mode=1; evaluated combinationally each cycle.
REQ-017 Each channel SHALL hold a one-entry register slot (valid flag plus WIDTH data).
REQ-018 in_ready SHALL be high iff slot t is empty, or slot t is full and out_ready[t] is high.
REQ-019 Input transfer occurs on a rising edge with in_valid and in_ready both high; in_data is written to slot t, which becomes full.
REQ-020 Output transfer on channel i occurs on a rising edge with out_valid[i] and out_ready[i] both high; the slot empties unless refilled on the same edge.
REQ-021 Simultaneous drain and refill of the same slot SHALL leave it full with the new data; no bubble, no loss.
REQ-022 Latency: a beat accepted at edge k SHALL be visible on out_valid/out_data immediately after edge k (one cycle).
REQ-023 Channels SHALL drain independently; a stalled channel SHALL NOT block beats targeting other channels.
REQ-024 A full slot SHALL hold its out_data stable until drained.
REQ-025 out_data of an empty channel SHALL hold its last value; it is not required to be zero.
REQ-026 rr_ptr SHALL advance by 1 modulo N only on an input transfer with mode=1; it wraps from N-1 to 0.
REQ-027 In mode=0, rr_ptr SHALL hold its value.
REQ-028 A mode change SHALL take effect on the next cycle's target computation; in-flight slots are unaffected.
REQ-029 xfer_cnt SHALL increment by 1 per input transfer in either mode; it wraps from 16'hFFFF to 0 without saturating.
REQ-030 When in_valid is low, no slot, rr_ptr or xfer_cnt update from the input side SHALL occur.

Reset
REQ-031 While rst_n is low, all outputs SHALL be: out_valid=0, out_data=0, rr_ptr=0, xfer_cnt=0.
REQ-032 in_ready SHALL follow REQ-018 from the reset slot state (all slots empty), so it reads high once in_valid is asserted.
REQ-033 Reset asserted mid-operation SHALL discard all held beats immediately, without waiting for a clock edge.
REQ-034 The first transfer is possible on the first rising edge after rst_n deasserts.

Structure
REQ-035 Package stream_demux_pkg SHALL hold DEFAULT_WIDTH, DEFAULT_N, and mode constants MODE_ADDR=1'b0 and MODE_RR=1'b1.
REQ-036 Sub-module demux_slot (one-entry register slice: wr_en, din, rd_ready, valid, dout) SHALL be instantiated N times via generate.

Verification
REQ-037 Reset, then mode=0, in_sel=3, in_data=8'hA5, in_valid pulse, out_ready=all 1 -> out_valid=8'b0000_1000 for one cycle, out_data[31:24]=8'hA5, xfer_cnt=1.
REQ-038 out_ready=0; mode=0; send in_sel=2 twice -> first beat accepted; in_ready low on the second beat; out_ready[2]=1 then drains the first beat and accepts the second on the same edge (REQ-021).
REQ-039 mode=1, out_ready=all 1; send 10 beats 0..9 -> channels 0,1,...,7,0,1 each receive their value; rr_ptr=2 at the end.
REQ-040 out_ready[5]=0; mode=0; beats to channel 5, then channel 6 -> channel 6 beat is delivered while channel 5 stays full with stable data.
REQ-041 Fill channels 1 and 4, assert rst_n=0 between clock edges -> out_valid=0 immediately; xfer_cnt=0; rr_ptr=0.
REQ-042 Preload 65535 transfers (or force xfer_cnt), then send one more beat -> xfer_cnt reads 0.
